// File: rtl/dpram_linebuf.sv
// Parametrised simple dual-port pixel RAM with a hardware clear (fill) engine.
// Optional macro DPRAM_RDW_BYPASS_EN forwards same-cycle write data to the read port.
module dpram_linebuf #(
  parameter int DATA_W       = 24,
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_drop,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_value,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

  generate
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("dpram_linebuf: READ_LATENCY must be 1 or 2");
    end
    if (DATA_W < 1 || DATA_W > 36) begin : g_bad_width
      $error("dpram_linebuf: DATA_W must be in 1..36");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t            state;
  logic [ADDR_W:0]   clr_cnt;
  logic [DATA_W-1:0] clr_val;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic              usr_we;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;

  // A reset landing mid-fill must not let the pending clear word through.
  assign clr_we = (state == CLEAR) && !reset;
  assign usr_we = wr_en && (state != CLEAR);
  assign we     = clr_we || usr_we;
  assign wa     = clr_we ? clr_cnt[ADDR_W-1:0] : wr_addr;
  assign wd     = clr_we ? clr_val : wr_data;

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      clr_cnt  <= '0;
      clr_val  <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
      wr_drop  <= 1'b0;
    end else begin
      wr_drop  <= wr_en && (state == CLEAR);
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_start) begin
            clr_val  <= clr_value;
            clr_cnt  <= '0;
            clr_busy <= 1'b1;
            state    <= CLEAR;
          end
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + CNT_ONE;
          if (clr_cnt == CNT_LAST) begin
            state    <= DONE;
            clr_done <= 1'b1;
          end
        end
        DONE: begin
          clr_busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          clr_busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  logic [DATA_W-1:0] mem_q;
  logic [DATA_W-1:0] rd_stage;
  logic              rd_v1;

  // Read-first: the non-blocking array write is not visible to this read.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '0;
      rd_v1 <= 1'b0;
    end else begin
      rd_v1 <= rd_en;
      if (rd_en) mem_q <= mem[rd_addr];
    end
  end

`ifdef DPRAM_RDW_BYPASS_EN
  logic              byp_hit;
  logic [DATA_W-1:0] byp_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      byp_hit  <= 1'b0;
      byp_data <= '0;
    end else if (rd_en) begin
      byp_hit  <= we && (wa == rd_addr);
      byp_data <= wd;
    end
  end

  assign rd_stage = byp_hit ? byp_data : mem_q;
`else
  assign rd_stage = mem_q;
`endif

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      always_ff @(posedge clk) begin
        if (reset) begin
          rd_data  <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= rd_v1;
          if (rd_v1) rd_data <= rd_stage;
        end
      end
    end else begin : g_lat1
      assign rd_data  = rd_stage;
      assign rd_valid = rd_v1;
    end
  endgenerate

endmodule

// File: tb/tb_dpram_linebuf.sv
// Directed and model-based bench for dpram_linebuf: a 24x1024 latency-1 instance
// and an 8x16 latency-2 instance sharing clock and reset.
module tb_dpram_linebuf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        a_wr_en, a_wr_drop, a_rd_en, a_rd_valid, a_clr_start, a_clr_busy, a_clr_done;
  logic [9:0]  a_wr_addr, a_rd_addr;
  logic [23:0] a_wr_data, a_rd_data, a_clr_value;

  logic        b_wr_en, b_wr_drop, b_rd_en, b_rd_valid, b_clr_start, b_clr_busy, b_clr_done;
  logic [3:0]  b_wr_addr, b_rd_addr;
  logic [7:0]  b_wr_data, b_rd_data, b_clr_value;

  dpram_linebuf #(.DATA_W(24), .ADDR_W(10), .READ_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_drop(a_wr_drop),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
    .clr_start(a_clr_start), .clr_value(a_clr_value), .clr_busy(a_clr_busy), .clr_done(a_clr_done)
  );

  dpram_linebuf #(.DATA_W(8), .ADDR_W(4), .READ_LATENCY(2)) dut_b (
    .clk(clk), .reset(reset),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_drop(b_wr_drop),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .clr_start(b_clr_start), .clr_value(b_clr_value), .clr_busy(b_clr_busy), .clr_done(b_clr_done)
  );

  int total = 0;
  int bad   = 0;

  // Free-running counts of busy cycles and done pulses; tests diff against a snapshot.
  int a_busy_cnt = 0;
  int a_done_cnt = 0;
  always @(negedge clk) begin
    if (a_clr_busy === 1'b1) a_busy_cnt++;
    if (a_clr_done === 1'b1) a_done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if ({a_rd_valid, a_wr_drop, a_clr_busy, a_clr_done} !== 4'b0000) begin
      bad++; $display("FAIL reset_a_flags got=%b exp=0000", {a_rd_valid, a_wr_drop, a_clr_busy, a_clr_done});
    end
    total++;
    if (a_rd_data !== 24'h0) begin
      bad++; $display("FAIL reset_a_rd_data got=%h exp=000000", a_rd_data);
    end
    total++;
    if ({b_rd_valid, b_wr_drop, b_clr_busy, b_clr_done} !== 4'b0000 || b_rd_data !== 8'h0) begin
      bad++; $display("FAIL reset_b got_flags=%b got_data=%h exp=0", {b_rd_valid, b_wr_drop, b_clr_busy, b_clr_done}, b_rd_data);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_rw_latency();
    a_wr_en = 1'b1; a_wr_addr = 10'd5; a_wr_data = 24'h123456;
    tick();
    a_wr_addr = 10'd1023; a_wr_data = 24'hABCDEF;
    tick();
    a_wr_en = 1'b0;
    a_rd_en = 1'b1; a_rd_addr = 10'd5;
    tick();
    total++;
    if (a_rd_valid !== 1'b1 || a_rd_data !== 24'h123456) begin
      bad++; $display("FAIL lat1_rd5 got=%b/%h exp=1/123456", a_rd_valid, a_rd_data);
    end
    a_rd_addr = 10'd1023;
    tick();
    total++;
    if (a_rd_valid !== 1'b1 || a_rd_data !== 24'hABCDEF) begin
      bad++; $display("FAIL lat1_rd1023 got=%b/%h exp=1/abcdef", a_rd_valid, a_rd_data);
    end
    a_rd_en = 1'b0;
    tick();
    total++;
    if (a_rd_valid !== 1'b0 || a_rd_data !== 24'hABCDEF) begin
      bad++; $display("FAIL lat1_hold got=%b/%h exp=0/abcdef", a_rd_valid, a_rd_data);
    end

    b_wr_en = 1'b1; b_wr_addr = 4'd5; b_wr_data = 8'h56;
    tick();
    b_wr_addr = 4'd15; b_wr_data = 8'hEF;
    tick();
    b_wr_en = 1'b0;
    b_rd_en = 1'b1; b_rd_addr = 4'd5;
    tick();
    total++;
    if (b_rd_valid !== 1'b0) begin
      bad++; $display("FAIL lat2_early_valid got=%b exp=0", b_rd_valid);
    end
    b_rd_addr = 4'd15;
    tick();
    total++;
    if (b_rd_valid !== 1'b1 || b_rd_data !== 8'h56) begin
      bad++; $display("FAIL lat2_rd5 got=%b/%h exp=1/56", b_rd_valid, b_rd_data);
    end
    b_rd_en = 1'b0;
    tick();
    total++;
    if (b_rd_valid !== 1'b1 || b_rd_data !== 8'hEF) begin
      bad++; $display("FAIL lat2_rd15 got=%b/%h exp=1/ef", b_rd_valid, b_rd_data);
    end
    tick();
    total++;
    if (b_rd_valid !== 1'b0 || b_rd_data !== 8'hEF) begin
      bad++; $display("FAIL lat2_hold got=%b/%h exp=0/ef", b_rd_valid, b_rd_data);
    end
  endtask

  task automatic test_rdw();
    logic [23:0] exp_rdw;
`ifdef DPRAM_RDW_BYPASS_EN
    exp_rdw = 24'h000022;
`else
    exp_rdw = 24'h000011;
`endif
    a_wr_en = 1'b1; a_wr_addr = 10'd7; a_wr_data = 24'h000011;
    tick();
    a_wr_data = 24'h000022;
    a_rd_en = 1'b1; a_rd_addr = 10'd7;
    tick();
    a_wr_en = 1'b0;
    total++;
    if (a_rd_valid !== 1'b1 || a_rd_data !== exp_rdw) begin
      bad++; $display("FAIL rdw_same_cycle got=%b/%h exp=1/%h", a_rd_valid, a_rd_data, exp_rdw);
    end
    tick();
    a_rd_en = 1'b0;
    total++;
    if (a_rd_data !== 24'h000022) begin
      bad++; $display("FAIL rdw_after got=%h exp=000022", a_rd_data);
    end
  endtask

  task automatic test_clear();
    int busy0, done0;
    logic [9:0] addrs [3];
    addrs[0] = 10'd0; addrs[1] = 10'd512; addrs[2] = 10'd1023;
    busy0 = a_busy_cnt; done0 = a_done_cnt;
    a_clr_value = 24'h0000FF; a_clr_start = 1'b1;
    tick();
    a_clr_start = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      if (a_clr_busy !== 1'b1) break;
      tick();
    end
    total++;
    if (a_clr_busy !== 1'b0 || (a_busy_cnt - busy0) != 1025) begin
      bad++; $display("FAIL clear_busy_len got=%0d busy_now=%b exp=1025", a_busy_cnt - busy0, a_clr_busy);
    end
    total++;
    if ((a_done_cnt - done0) != 1) begin
      bad++; $display("FAIL clear_done_count got=%0d exp=1", a_done_cnt - done0);
    end
    a_rd_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a_rd_addr = addrs[k];
      tick();
      total++;
      if (a_rd_data !== 24'h0000FF) begin
        bad++; $display("FAIL clear_read addr=%0d got=%h exp=0000ff", addrs[k], a_rd_data);
      end
    end
    a_rd_en = 1'b0;
  endtask

  task automatic test_clear_drop();
    int busy0, done0;
    busy0 = a_busy_cnt; done0 = a_done_cnt;
    a_clr_value = 24'h5A5A5A; a_clr_start = 1'b1;
    tick();
    a_clr_start = 1'b0;
    repeat (10) tick();
    a_wr_en = 1'b1; a_wr_addr = 10'd3; a_wr_data = 24'h777777; a_clr_start = 1'b1;
    tick();
    a_wr_en = 1'b0; a_clr_start = 1'b0;
    total++;
    if (a_wr_drop !== 1'b1) begin
      bad++; $display("FAIL drop_pulse got=%b exp=1", a_wr_drop);
    end
    tick();
    total++;
    if (a_wr_drop !== 1'b0) begin
      bad++; $display("FAIL drop_single got=%b exp=0", a_wr_drop);
    end
    for (int i = 0; i < 1200; i++) begin
      if (a_clr_busy !== 1'b1) break;
      tick();
    end
    repeat (5) tick();
    total++;
    if ((a_busy_cnt - busy0) != 1025 || (a_done_cnt - done0) != 1) begin
      bad++; $display("FAIL drop_no_restart busy=%0d done=%0d exp=1025/1", a_busy_cnt - busy0, a_done_cnt - done0);
    end
    a_rd_en = 1'b1; a_rd_addr = 10'd3;
    tick();
    a_rd_en = 1'b0;
    total++;
    if (a_rd_data !== 24'h5A5A5A) begin
      bad++; $display("FAIL drop_mem3 got=%h exp=5a5a5a", a_rd_data);
    end
  endtask

  task automatic test_reset_mid_clear();
    int busy0, done0;
    logic [9:0]  addrs [4];
    logic [23:0] exps [4];
    addrs[0] = 10'd50;  exps[0] = 24'hC1C1C1;
    addrs[1] = 10'd99;  exps[1] = 24'hC1C1C1;
    addrs[2] = 10'd900; exps[2] = 24'h090090;
    addrs[3] = 10'd1023; exps[3] = 24'h5A5A5A;
    a_wr_en = 1'b1; a_wr_addr = 10'd900; a_wr_data = 24'h090090;
    tick();
    a_wr_en = 1'b0;
    busy0 = a_busy_cnt; done0 = a_done_cnt;
    a_clr_value = 24'hC1C1C1; a_clr_start = 1'b1;
    tick();
    a_clr_start = 1'b0;
    a_rd_en = 1'b1; a_rd_addr = 10'd900;
    repeat (100) tick();
    reset = 1'b1; a_rd_en = 1'b0;
    tick();
    reset = 1'b0;
    total++;
    if ({a_clr_busy, a_rd_valid, a_clr_done} !== 3'b000 || a_rd_data !== 24'h0) begin
      bad++; $display("FAIL midreset_outputs got=%b/%h exp=000/000000", {a_clr_busy, a_rd_valid, a_clr_done}, a_rd_data);
    end
    repeat (1100) tick();
    total++;
    if ((a_done_cnt - done0) != 0 || (a_busy_cnt - busy0) != 101) begin
      bad++; $display("FAIL midreset_abort done=%0d busy=%0d exp=0/101", a_done_cnt - done0, a_busy_cnt - busy0);
    end
    a_rd_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a_rd_addr = addrs[k];
      tick();
      total++;
      if (a_rd_data !== exps[k]) begin
        bad++; $display("FAIL midreset_read addr=%0d got=%h exp=%h", addrs[k], a_rd_data, exps[k]);
      end
    end
    a_rd_en = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] model [16];
    logic       vp0, vp1;
    logic [7:0] dp0, dp1, exp_data;
    logic       re, we;
    logic [3:0] ra, wa;
    logic [7:0] wd;
    b_clr_value = 8'h3C; b_clr_start = 1'b1;
    tick();
    b_clr_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (b_clr_busy !== 1'b1) break;
      tick();
    end
    total++;
    if (b_clr_busy !== 1'b0) begin
      bad++; $display("FAIL rand_clear_timeout got=%b exp=0", b_clr_busy);
    end
    for (int k = 0; k < 16; k++) model[k] = 8'h3C;
    vp0 = 1'b0; vp1 = 1'b0; dp0 = 8'h0; dp1 = 8'h0; exp_data = 8'h0;
    for (int c = 0; c < 10000; c++) begin
      if (vp1) exp_data = dp1;
      total++;
      if (b_rd_valid !== vp1 || b_rd_data !== exp_data) begin
        bad++; $display("FAIL rand cyc=%0d got=%b/%h exp=%b/%h", c, b_rd_valid, b_rd_data, vp1, exp_data);
      end
      vp1 = vp0; dp1 = dp0;
      re = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      ra = 4'($urandom_range(0, 15));
      wa = 4'($urandom_range(0, 15));
      wd = 8'($urandom_range(0, 255));
      vp0 = re;
      if (re) begin
        dp0 = model[ra];
`ifdef DPRAM_RDW_BYPASS_EN
        if (we && wa == ra) dp0 = wd;
`endif
      end
      if (we) model[wa] = wd;
      b_rd_en = re; b_rd_addr = ra; b_wr_en = we; b_wr_addr = wa; b_wr_data = wd;
      tick();
    end
    b_rd_en = 1'b0; b_wr_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0; a_rd_en = 1'b0; a_rd_addr = '0;
    a_clr_start = 1'b0; a_clr_value = '0;
    b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_rd_en = 1'b0; b_rd_addr = '0;
    b_clr_start = 1'b0; b_clr_value = '0;
    test_reset();
    test_rw_latency();
    test_rdw();
    test_clear();
    test_clear_drop();
    test_reset_mid_clear();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
